// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback bus of regfile_wb_arbiter.
//   ALU source    : alu_valid, alu_addr, alu_data -> alu_ready
//   Memory source : mem_valid, mem_addr, mem_data -> mem_ready
//   Issue         : issue_valid, issue_addr (marks a destination busy)
//   Write port    : Ad_c, data_wr, wr_acc (to the 32x64 register file)
//   Status        : busy (per-register outstanding write), conflict_cnt
// The slave modport is the arbiter's view; master is the environment's view.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] Ad_c;
  logic [DATA_W-1:0] data_wr;
  logic              wr_acc;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr,
    output alu_ready, mem_ready,
    output Ad_c, data_wr, wr_acc, busy, conflict_cnt
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr,
    input  alu_ready, mem_ready,
    input  Ad_c, data_wr, wr_acc, busy, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU and memory writeback sources, with a busy scoreboard and a
// saturating contention counter.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (sources, issue, write port, status)
// Readies are combinational from the valids and the last-grant pointer; the
// write port is registered one cycle after acceptance.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic              r_last_mem;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic [NREG-1:0]   r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_alu_rdy;
  logic              w_mem_rdy;
  logic              w_both;
  logic [NREG-1:0]   w_busy_nxt;

  // ---- stage p0: combinational grant ----
  // On contention the source not granted last wins; r_last_mem = 1 means
  // the memory unit had the most recent grant.
  assign w_both    = bus.alu_valid & bus.mem_valid;
  assign w_alu_rdy = ~rst & bus.alu_valid & (~bus.mem_valid | r_last_mem);
  assign w_mem_rdy = ~rst & bus.mem_valid & (~bus.alu_valid | ~r_last_mem);

  assign bus.alu_ready = w_alu_rdy;
  assign bus.mem_ready = w_mem_rdy;

  // Clear for the write on the port this cycle is applied first so that a
  // same-register issue in the same cycle leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_vld_p1)        w_busy_nxt[r_addr_p1]      = 1'b0;
    if (bus.issue_valid) w_busy_nxt[bus.issue_addr] = 1'b1;
  end

  // ---- stage p1: registered write port and status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_mem <= 1'b1;
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_data_p1  <= '0;
      r_busy     <= '0;
      r_cnt      <= '0;
    end else begin
      r_vld_p1 <= w_alu_rdy | w_mem_rdy;
      if (w_alu_rdy) begin
        r_addr_p1  <= bus.alu_addr;
        r_data_p1  <= bus.alu_data;
        r_last_mem <= 1'b0;
      end else if (w_mem_rdy) begin
        r_addr_p1  <= bus.mem_addr;
        r_data_p1  <= bus.mem_data;
        r_last_mem <= 1'b1;
      end
      r_busy <= w_busy_nxt;
      if (w_both) r_cnt <= sat_inc(r_cnt);
    end
  end

  assign bus.wr_acc       = r_vld_p1;
  assign bus.Ad_c         = r_addr_p1;
  assign bus.data_wr      = r_data_p1;
  assign bus.busy         = r_busy;
  assign bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(16)) bus ();
  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(2))  bus2 ();

  assign bus2.alu_valid   = bus.alu_valid;
  assign bus2.alu_addr    = bus.alu_addr;
  assign bus2.alu_data    = bus.alu_data;
  assign bus2.mem_valid   = bus.mem_valid;
  assign bus2.mem_addr    = bus.mem_addr;
  assign bus2.mem_data    = bus.mem_data;
  assign bus2.issue_valid = bus.issue_valid;
  assign bus2.issue_addr  = bus.issue_addr;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state (reset values)
  bit          m_last_mem = 1'b1;
  logic [31:0] m_busy = '0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;
  bit          m_wr_vld = 1'b0;
  logic [4:0]  m_wr_addr = '0;

  bit d_alu, d_mem;
  bit started = 1'b0;
  bit rst_prev = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [63:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setin(input bit av, input logic [4:0] aa, input logic [63:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [63:0] md,
                       input bit iv, input logic [4:0] ia);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_addr = ia;
  endtask

  task automatic idle();
    setin(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: inputs are already applied; compare, update model, advance.
  task automatic cycle();
    bit ea, em;
    @(negedge clk);
    if (rst) begin
      ea = 0; em = 0;
    end else begin
      ea = bus.alu_valid && (!bus.mem_valid || m_last_mem);
      em = bus.mem_valid && (!bus.alu_valid || !m_last_mem);
    end
    d_alu = bus.alu_ready;
    d_mem = bus.mem_ready;
    chk("alu_ready", 64'(bus.alu_ready), 64'(ea));
    chk("mem_ready", 64'(bus.mem_ready), 64'(em));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
    chk("conflict_cnt_w2", 64'(bus2.conflict_cnt), 64'(m_cnt2));
    if (rst) begin
      m_busy = '0; m_cnt = 0; m_cnt2 = 0; m_last_mem = 1'b1; m_wr_vld = 1'b0;
    end else begin
      if (m_wr_vld) m_busy[m_wr_addr] = 1'b0;
      if (bus.issue_valid) m_busy[bus.issue_addr] = 1'b1;
      if (bus.alu_valid && bus.mem_valid) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_wr_vld = ea | em;
      if (ea) begin
        q.push_back('{cyc, bus.alu_addr, bus.alu_data});
        m_wr_addr = bus.alu_addr; m_last_mem = 1'b0;
      end
      if (em) begin
        q.push_back('{cyc, bus.mem_addr, bus.mem_data});
        m_wr_addr = bus.mem_addr; m_last_mem = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: checks the write port against the scoreboard queue.
  always @(negedge clk) begin
    if (started) begin
      if (rst_prev) begin
        chk("reset_wr_acc", 64'(bus.wr_acc), 64'd0);
        chk("reset_Ad_c", 64'(bus.Ad_c), 64'd0);
        chk("reset_data_wr", bus.data_wr, 64'd0);
        last_addr = '0; last_data = '0;
        while (q.size() > 0 && q[0].cyc + 1 <= cyc) void'(q.pop_front());
      end else if (bus.wr_acc) begin
        checks++;
        if (q.size() == 0 || q[0].cyc + 1 != cyc) begin
          failures++;
          $display("FAIL unexpected_write: wr_acc=1 Ad_c=%0d with no write due (cycle %0d)", bus.Ad_c, cyc);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("write_Ad_c", 64'(bus.Ad_c), 64'(e.addr));
          chk("write_data_wr", bus.data_wr, e.data);
          last_addr = e.addr; last_data = e.data;
        end
      end else begin
        chk("hold_Ad_c", 64'(bus.Ad_c), 64'(last_addr));
        chk("hold_data_wr", bus.data_wr, last_data);
        if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
          checks++; failures++;
          $display("FAIL missing_write: wr_acc=0, required write to %0d (cycle %0d)", q[0].addr, cyc);
          void'(q.pop_front());
        end
      end
    end
    rst_prev = rst;
    if (rst) started = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] glog;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Single ALU write
    setin(1, 1, 64'h1, 0, 0, 0, 0, 0); cycle();
    chk("t1_alu_ready", 64'(d_alu), 64'd1);
    idle(); cycle(); cycle();

    // Contention round-robin
    do_reset();
    glog = '0;
    setin(1, 2, 64'hA, 1, 3, 64'hB, 0, 0);
    repeat (4) begin
      cycle();
      glog = {glog[2:0], d_alu};
    end
    idle(); cycle();
    chk("t2_grant_order", 64'(glog), 64'b1010);
    chk("t2_conflict_cnt", 64'(bus.conflict_cnt), 64'd4);
    cycle();

    // Scoreboard set / clear
    do_reset();
    setin(0, 0, 0, 0, 0, 0, 1, 5); cycle();
    idle(); cycle();
    setin(1, 5, 64'h5, 0, 0, 0, 0, 0); cycle();
    idle(); cycle();
    cycle();
    chk("t3_busy5_cleared", 64'(bus.busy[5]), 64'd0);
    setin(0, 0, 0, 0, 0, 0, 1, 5); cycle();
    setin(1, 5, 64'h5, 0, 0, 0, 0, 0); cycle();
    setin(0, 0, 0, 0, 0, 0, 1, 5); cycle();
    idle(); cycle();
    chk("t3_busy5_set_wins", 64'(bus.busy[5]), 64'd1);

    // Same-address race
    do_reset();
    setin(1, 0, 64'h1, 1, 0, 64'h2, 0, 0); cycle();
    setin(0, 0, 0, 1, 0, 64'h2, 0, 0); cycle();
    idle(); cycle(); cycle();
    chk("t4_final_addr", 64'(last_addr), 64'd0);
    chk("t4_final_data", last_data, 64'h2);

    // Reset mid-write
    do_reset();
    setin(1, 4, 64'h44, 1, 6, 64'h66, 1, 4); cycle();
    rst = 1'b1;
    setin(1, 7, 64'h77, 1, 6, 64'h66, 0, 0); cycle();
    rst = 1'b0;
    cycle();
    chk("t5_post_reset_alu_grant", 64'(d_alu), 64'd1);
    idle(); cycle(); cycle();

    // Counter saturation on the CNT_W=2 instance
    do_reset();
    setin(1, 8, 64'h8, 1, 9, 64'h9, 0, 0);
    repeat (6) cycle();
    idle(); cycle();
    chk("t6_cnt2_saturated", 64'(bus2.conflict_cnt), 64'd3);
    cycle();

    // Randomized traffic
    do_reset();
    idle();
    d_alu = 0; d_mem = 0;
    repeat (400) begin
      if (!bus.alu_valid || d_alu) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_addr  = 5'($urandom);
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!bus.mem_valid || d_mem) begin
        bus.mem_valid = ($urandom_range(0, 3) != 0);
        bus.mem_addr  = 5'($urandom);
        bus.mem_data  = {$urandom, $urandom};
      end
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_addr  = 5'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    repeat (3) cycle();
    chk("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (Ad_c / data_wr / wr_acc) between two writeback sources: the ALU and the memory unit.
- Each source uses a valid/ready handshake. Contention is resolved round-robin.
- Sits between the execute/memory stages and the 32x64 register file.
- Also keeps a busy scoreboard of registers with writes in flight, used by issue logic for hazard stalls, plus a saturating contention counter.

Parameters:
- DATA_W, 64, writeback data width (matches register file data_wr)
- ADDR_W, 5, register address width (matches Ad_c)
- NREG, 32, number of registers tracked by the scoreboard (2**ADDR_W)
- CNT_W, 16, width of the contention counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU has a writeback pending
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU writeback accepted this cycle
- mem_valid  in  1  memory unit has a writeback pending
- mem_addr  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  memory writeback accepted this cycle
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_addr  in  ADDR_W  destination of the issuing instruction
- Ad_c  out  ADDR_W  register file write address
- data_wr  out  DATA_W  register file write data
- wr_acc  out  1  register file write enable
- busy  out  NREG  bit r = 1: write to register r outstanding
- conflict_cnt  out  CNT_W  cycles in which both sources were valid

Behaviour:
- Reset: every output is 0 on the cycle after rst is sampled high. This covers Ad_c, data_wr, wr_acc, busy, conflict_cnt and the ready outputs. The RR pointer resets to "last = MEM", so the ALU wins the first contention. While rst = 1, alu_ready = mem_ready = 0 and nothing is accepted.
- Ready generation is combinational from the valid inputs and the pointer:
  - only alu_valid: alu_ready = 1
  - only mem_valid: mem_ready = 1
  - both valid: ready goes to the source not granted last
  - never both readies in one cycle
- Acceptance: valid & ready in cycle N.
- Pointer: updates on every acceptance to the source just granted.
- Write stage (registered, latency 1):
  - Acceptance in cycle N gives wr_acc = 1 in cycle N+1, with Ad_c / data_wr = accepted addr/data.
  - The register file commits at the end of N+1.
  - wr_acc is high for exactly one cycle per acceptance. With no acceptance in N, wr_acc = 0 in N+1 and Ad_c / data_wr hold their previous values.
  - Back-to-back acceptances give one write per cycle with no bubbles. Sustained throughput is 1 write/cycle.
- Source rules: sources hold valid/addr/data stable until accepted. The losing source is not buffered; it stays pending.
- Same address from both sources in one cycle: handled only by RR order. Both eventually write, in grant order, and no merge is performed.
- Scoreboard, at each rising edge:
  - Set: if issue_valid, busy[issue_addr] is set.
  - Clear: if wr_acc in the current cycle, busy[Ad_c] is cleared.
  - Set and clear of the same register in the same edge: set wins, because a newer writer is outstanding.
  - Set and clear of different registers: both apply.
  - Re-issue to an already-busy register keeps it busy. No count is kept; the issue logic guarantees at most one outstanding writer per register.
- conflict_cnt: increments each cycle (not in reset) with alu_valid & mem_valid. It saturates at 2**CNT_W - 1 and does not wrap.
- Reset mid-operation:
  - A pending write stage is discarded: wr_acc = 0 the next cycle and that write is lost.
  - busy is cleared and the pointer is restored.
  - Sources must re-present after reset.
- No X propagation: outputs are fully defined whenever rst has been applied once.

Test Plan:
- Single ALU write: after reset, alu_valid = 1, alu_addr = 1, alu_data = 64'h1 in cycle N. Required: alu_ready = 1 in N; in N+1 wr_acc = 1, Ad_c = 1, data_wr = 64'h1; in N+2 wr_acc = 0.
- Contention round-robin: both valid for 4 cycles (alu_addr = 2 / data 64'hA, mem_addr = 3 / data 64'hB), each source deasserting after its own acceptance and re-presenting once. Required grant order ALU, MEM, ALU, MEM; wr_acc high 4 consecutive cycles; conflict_cnt = 4.
- Scoreboard set/clear: issue_valid with issue_addr = 5, then a 64'h5 write to register 5 accepted two cycles later. Required: busy[5] = 1 from issue+1 until the edge ending the wr_acc cycle, then 0. In a second pass, issue_valid with issue_addr = 5 in the same cycle as the wr_acc with Ad_c = 5: busy[5] stays 1.
- Same-address race: ALU and MEM both target register 0 with 64'h1 and 64'h2 (pointer last = MEM). Required: writes in ALU-then-MEM order on consecutive cycles; final data_wr = 64'h2 for Ad_c = 0.
- Reset mid-write: accept alu_addr = 4 in cycle N, assert rst in N+1. Required: in N+2 wr_acc = 0, busy = 0, conflict_cnt = 0, readies 0 during rst; the next contention after reset is granted to ALU.
- Counter saturation (CNT_W overridden to 2): hold both valid for 6 cycles. Required: conflict_cnt reaches 3 and stays at 3.
